// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multicycle MIPS control unit.
//   - state_t : FSM state enumeration (4-bit encoding)
//   - OP_*    : instruction opcode field values
//   - FN_*    : R-type funct field values
//   - ALU_*   : ALU operation codes driven on ALUSel (zero-extended by users)
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_RTYPEEX = 4'd6,
        ST_RTYPEWB = 4'd7,
        ST_BEQEX   = 4'd8,
        ST_BNEEX   = 4'd9,
        ST_ADDIEX  = 4'd10,
        ST_ADDIWB  = 4'd11,
        ST_JEX     = 4'd12,
        ST_ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/mc_funct_decoder.sv
// mc_funct_decoder: combinational R-type funct decode.
//   funct  in  OPW   function field of the instruction
//   alusel out SELW  ALU operation for the funct (ADD when not legal)
//   legal  out 1     funct is one of add/sub/and/or/slt
module mc_funct_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int SELW = 4
) (
    input  logic [OPW-1:0]  funct,
    output logic [SELW-1:0] alusel,
    output logic            legal
);

    always_comb begin
        alusel = SELW'(ALU_ADD);
        legal  = 1'b1;
        if (funct == OPW'(FN_ADD)) begin
            alusel = SELW'(ALU_ADD);
        end else if (funct == OPW'(FN_SUB)) begin
            alusel = SELW'(ALU_SUB);
        end else if (funct == OPW'(FN_AND)) begin
            alusel = SELW'(ALU_AND);
        end else if (funct == OPW'(FN_OR)) begin
            alusel = SELW'(ALU_OR);
        end else if (funct == OPW'(FN_SLT)) begin
            alusel = SELW'(ALU_SLT);
        end else begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore control FSM for a multicycle MIPS datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives datapath enables and mux selects from the current state.
//   CLK, RST            clock, synchronous active-high reset
//   Opcode, Funct       instruction register fields
//   Zero                ALU zero flag (branch resolution)
//   MemReady            memory access completes this cycle (stall handshake)
//   ALUSel, ALUSrcA/B   ALU operation and operand selects
//   PCSrc, IorD         PC source and memory address selects
//   IRWE, PCEn, DMWE,
//   RFWE                write enables
//   RFDSel, MtoRFSel    register file destination / writeback data selects
//   IllegalOp           one-cycle pulse on an unsupported opcode or funct
//   InstrDone           one-cycle pulse in the final cycle of an instruction
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int SELW = 4   // must be at least 4 to hold the ALU codes
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [OPW-1:0]  Opcode,
    input  logic [OPW-1:0]  Funct,
    input  logic            Zero,
    input  logic            MemReady,
    output logic [SELW-1:0] ALUSel,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSrc,
    output logic            IorD,
    output logic            IRWE,
    output logic            PCEn,
    output logic            DMWE,
    output logic            RFWE,
    output logic            RFDSel,
    output logic            MtoRFSel,
    output logic            IllegalOp,
    output logic            InstrDone
);

    state_t state_reg;
    state_t state_next;
    state_t decode_next;

    logic [SELW-1:0] funct_alusel;
    logic            funct_legal;

    mc_funct_decoder #(
        .OPW  (OPW),
        .SELW (SELW)
    ) u_funct_decoder (
        .funct  (Funct),
        .alusel (funct_alusel),
        .legal  (funct_legal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Opcode dispatch out of DECODE. Anything unrecognised, including an
    // R-type with an unknown funct, lands in ILLEGAL.
    always_comb begin
        decode_next = ST_ILLEGAL;
        if (Opcode == OPW'(OP_LW) || Opcode == OPW'(OP_SW)) begin
            decode_next = ST_MEMADR;
        end else if (Opcode == OPW'(OP_RTYPE)) begin
            decode_next = funct_legal ? ST_RTYPEEX : ST_ILLEGAL;
        end else if (Opcode == OPW'(OP_BEQ)) begin
            decode_next = ST_BEQEX;
        end else if (Opcode == OPW'(OP_BNE)) begin
            decode_next = ST_BNEEX;
        end else if (Opcode == OPW'(OP_ADDI)) begin
            decode_next = ST_ADDIEX;
        end else if (Opcode == OPW'(OP_J)) begin
            decode_next = ST_JEX;
        end
    end

    always_comb begin
        state_next = state_reg;
        ALUSel     = SELW'(ALU_ADD);
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        IorD       = 1'b0;
        IRWE       = 1'b0;
        PCEn       = 1'b0;
        DMWE       = 1'b0;
        RFWE       = 1'b0;
        RFDSel     = 1'b0;
        MtoRFSel   = 1'b0;
        IllegalOp  = 1'b0;
        InstrDone  = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                // PC+4 is written together with the IR once memory answers.
                ALUSrcB = 2'b01;
                IRWE    = MemReady;
                PCEn    = MemReady;
                if (MemReady) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                ALUSrcB    = 2'b11;
                state_next = decode_next;
            end
            ST_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (Opcode == OPW'(OP_LW)) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                IorD = 1'b1;
                if (MemReady) state_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                MtoRFSel   = 1'b1;
                RFWE       = 1'b1;
                InstrDone  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEMWR: begin
                // Write strobe stays up for the whole wait so the memory can
                // complete at its own pace.
                IorD      = 1'b1;
                DMWE      = 1'b1;
                InstrDone = MemReady;
                if (MemReady) state_next = ST_FETCH;
            end
            ST_RTYPEEX: begin
                ALUSrcA    = 1'b1;
                ALUSel     = funct_alusel;
                state_next = ST_RTYPEWB;
            end
            ST_RTYPEWB: begin
                RFDSel     = 1'b1;
                RFWE       = 1'b1;
                InstrDone  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BEQEX, ST_BNEEX: begin
                ALUSrcA    = 1'b1;
                ALUSel     = SELW'(ALU_SUB);
                PCSrc      = 2'b01;
                PCEn       = (state_reg == ST_BEQEX) ? Zero : ~Zero;
                InstrDone  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                RFWE       = 1'b1;
                InstrDone  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_JEX: begin
                PCSrc      = 2'b10;
                PCEn       = 1'b1;
                InstrDone  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_ILLEGAL: begin
                // PC already advanced in FETCH; just flag and move on.
                IllegalOp  = 1'b1;
                state_next = ST_FETCH;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // Reset silences every output so an aborted instruction cannot
        // commit anything in the reset cycle.
        if (RST) begin
            ALUSel    = '0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            PCSrc     = 2'b00;
            IorD      = 1'b0;
            IRWE      = 1'b0;
            PCEn      = 1'b0;
            DMWE      = 1'b0;
            RFWE      = 1'b0;
            RFDSel    = 1'b0;
            MtoRFSel  = 1'b0;
            IllegalOp = 1'b0;
            InstrDone = 1'b0;
        end
    end

endmodule
